// File: rtl/inv_serial_pkg.sv
// Shared types and logical line levels for the inverted-line serial receiver.
package inv_serial_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam logic L_IDLE  = 1'b1;
  localparam logic L_START = 1'b0;
  localparam logic L_STOP  = 1'b1;

endpackage

// File: rtl/line_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input; reset value is
// chosen by the instantiating block so the output sits at its idle level.
module line_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RESET_VAL;
      r_q    <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/inv_serial_rx.sv
// Serial frame receiver: synchronizes and de-inverts the line, samples each
// bit at mid-bit, checks the stop bit and pulses data_valid or frame_err.
module inv_serial_rx
  import inv_serial_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter bit          INVERT       = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 line_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

  logic                 w_sync;
  logic                 w_l;
  rx_state_t            r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_ferr;
  logic                 r_busy;

  // Synchronizer resets to the physical idle level so the logical line reads idle.
  line_sync #(
    .RESET_VAL (L_IDLE ^ INVERT)
  ) u_line_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (line_in),
    .o_q   (w_sync)
  );

  assign w_l = w_sync ^ INVERT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_l == L_START) begin
            r_bit_cnt <= '0;
            r_cnt     <= HALF_LOAD;
            r_state   <= START;
            r_busy    <= 1'b1;
          end
        end
        START: begin
          if (r_cnt == '0) begin
            // Start bit must still be low at mid-bit, otherwise it was a glitch.
            if (w_l == L_START) begin
              r_cnt   <= FULL_LOAD;
              r_state <= DATA;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        DATA: begin
          if (r_cnt == '0) begin
            r_shift   <= {w_l, r_shift[DATA_BITS-1:1]};
            r_cnt     <= FULL_LOAD;
            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            if (r_bit_cnt == LAST_BIT) begin
              r_state <= STOP;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        STOP: begin
          if (r_cnt == '0) begin
            if (w_l == L_STOP) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
            end else begin
              r_ferr <= 1'b1;
            end
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign frame_err  = r_ferr;
  assign busy       = r_busy;

endmodule

// File: tb/tb_inv_serial_rx.sv
// Randomized bench for inv_serial_rx: inverted and true-polarity instances see
// the same logical stimulus and are checked each cycle against a frame model.
module tb_inv_serial_rx;

  localparam int CPB  = 4;
  localparam int DB   = 8;
  localparam int HALF = CPB / 2;
  localparam int FLEN = HALF + CPB * (DB + 1);  // detect edge to stop-sample edge

  typedef struct {
    int         idx;
    bit         is_err;
    logic [7:0] d;
  } pulse_t;

  logic       clk;
  logic       rst_n;
  logic       lg;
  logic       line_inv;
  logic       line_true;
  logic [7:0] do_i, do_t;
  logic       dv_i, dv_t, fe_i, fe_t, bz_i, bz_t;

  int         checks;
  int         errors;
  int         chk_idx;

  bit         lv[$];
  logic       e_busy[];
  logic       e_valid[];
  logic       e_ferr[];
  logic [7:0] e_data[];
  pulse_t     pq_inv[$];
  pulse_t     pq_true[$];
  bit         bh_inv[$];

  assign line_inv  = ~lg;
  assign line_true = lg;

  inv_serial_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .INVERT(1'b1)) u_inv (
    .clk        (clk),
    .rst_n      (rst_n),
    .line_in    (line_inv),
    .data_out   (do_i),
    .data_valid (dv_i),
    .frame_err  (fe_i),
    .busy       (bz_i)
  );

  inv_serial_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .INVERT(1'b0)) u_true (
    .clk        (clk),
    .rst_n      (rst_n),
    .line_in    (line_true),
    .data_out   (do_t),
    .data_valid (dv_t),
    .frame_err  (fe_t),
    .busy       (bz_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  // Logical line level the receiver acts on at edge n (two edges of synchronizer delay).
  function automatic bit lvl(input int n);
    if (n >= 2) return lv[n-2];
    return 1'b1;
  endfunction

  task automatic mark_busy(input int a, input int b);
    for (int i = a; i <= b; i++) e_busy[i] = 1'b1;
  endtask

  // Frame-level reference: scan the line array for start bits and decode whole frames.
  task automatic build_model(input logic [7:0] d0);
    int         n, s, e, len;
    logic [7:0] w;
    len     = lv.size();
    e_busy  = new[len];
    e_valid = new[len];
    e_ferr  = new[len];
    e_data  = new[len];
    for (int i = 0; i < len; i++) begin
      e_busy[i] = 1'b0; e_valid[i] = 1'b0; e_ferr[i] = 1'b0; e_data[i] = d0;
    end
    n = 0;
    while (n < len) begin
      if (lvl(n) == 1'b0) begin
        s = n + HALF;
        e = n + FLEN;
        if (s >= len) begin
          mark_busy(n, len - 1); n = len;
        end else if (lvl(s) == 1'b1) begin
          mark_busy(n, s - 1); n = s + 1;
        end else if (e >= len) begin
          mark_busy(n, len - 1); n = len;
        end else begin
          for (int k = 1; k <= DB; k++) w[k-1] = lvl(s + CPB * k);
          mark_busy(n, e - 1);
          if (lvl(e) == 1'b1) begin
            e_valid[e] = 1'b1;
            for (int i = e; i < len; i++) e_data[i] = w;
          end else begin
            e_ferr[e] = 1'b1;
          end
          n = e + 1;
        end
      end else begin
        n++;
      end
    end
  endtask

  task automatic add_idle(input int cnt);
    repeat (cnt) lv.push_back(1'b1);
  endtask

  task automatic add_frame(input logic [7:0] d, input bit stop, output int start);
    start = lv.size();
    repeat (CPB) lv.push_back(1'b0);
    for (int b = 0; b < DB; b++) repeat (CPB) lv.push_back(d[b]);
    repeat (CPB) lv.push_back(stop);
  endtask

  task automatic run_seg();
    pq_inv.delete();
    pq_true.delete();
    bh_inv.delete();
    for (int i = 0; i < lv.size(); i++) begin
      lg = lv[i];
      @(posedge clk);
      #1;
      chk_idx = i;
    end
    @(negedge clk);
    #1;
    chk_idx = -1;
  endtask

  task automatic chk_zero(input int idx);
    chk("rst.inv.data", idx, 32'(do_i), 32'd0);
    chk("rst.inv.flags", idx, 32'({dv_i, fe_i, bz_i}), 32'd0);
    chk("rst.true.data", idx, 32'(do_t), 32'd0);
    chk("rst.true.flags", idx, 32'({dv_t, fe_t, bz_t}), 32'd0);
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_idx >= 0) begin
      chk("inv.busy",  chk_idx, 32'(bz_i), 32'(e_busy[chk_idx]));
      chk("inv.valid", chk_idx, 32'(dv_i), 32'(e_valid[chk_idx]));
      chk("inv.ferr",  chk_idx, 32'(fe_i), 32'(e_ferr[chk_idx]));
      chk("inv.data",  chk_idx, 32'(do_i), 32'(e_data[chk_idx]));
      chk("true.busy",  chk_idx, 32'(bz_t), 32'(e_busy[chk_idx]));
      chk("true.valid", chk_idx, 32'(dv_t), 32'(e_valid[chk_idx]));
      chk("true.ferr",  chk_idx, 32'(fe_t), 32'(e_ferr[chk_idx]));
      chk("true.data",  chk_idx, 32'(do_t), 32'(e_data[chk_idx]));
      bh_inv.push_back(bz_i);
      if (dv_i || fe_i) pq_inv.push_back('{chk_idx, fe_i, do_i});
      if (dv_t || fe_t) pq_true.push_back('{chk_idx, fe_t, do_t});
    end
  end

  initial begin
    int         s_a5, s_00, s_ff, s_3c, s_5a, s_81, s_12, g_idx, bcnt;
    logic [7:0] last_d;
    checks  = 0;
    errors  = 0;
    chk_idx = -1;
    lg      = 1'b1;
    rst_n   = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk_zero(-1);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Segment 1: directed frames, glitch, bad stop, then random traffic and noise.
    lv.delete();
    add_idle(5);
    add_frame(8'hA5, 1'b1, s_a5);
    add_idle(6);
    add_frame(8'h00, 1'b1, s_00);
    add_frame(8'hFF, 1'b1, s_ff);
    add_idle(6);
    g_idx = lv.size();
    lv.push_back(1'b0);
    add_idle(8);
    add_frame(8'h3C, 1'b0, s_3c);
    add_idle(8);
    for (int r = 0; r < 25; r++) begin
      int tmp;
      add_idle(int'($urandom_range(0, 4)));
      if ($urandom_range(0, 5) == 0) begin
        repeat ($urandom_range(1, 2)) lv.push_back(1'b0);
        add_idle(3);
      end
      add_frame(8'($urandom), ($urandom_range(0, 7) != 0), tmp);
    end
    add_idle(4);
    repeat (60) lv.push_back(1'($urandom_range(0, 1)));
    add_idle(60);
    build_model(8'h00);
    last_d = e_data[lv.size() - 1];
    run_seg();

    chk("seg1.npulses_ge4", 0, 32'(pq_inv.size() >= 4), 32'd1);
    if (pq_inv.size() >= 4) begin
      chk("a5.idx",  pq_inv[0].idx, 32'(pq_inv[0].idx - s_a5), 32'd40);
      chk("a5.data", pq_inv[0].idx, 32'(pq_inv[0].d), 32'hA5);
      chk("a5.kind", pq_inv[0].idx, 32'(pq_inv[0].is_err), 32'd0);
      chk("b2b0.data", pq_inv[1].idx, 32'(pq_inv[1].d), 32'h00);
      chk("b2b1.data", pq_inv[2].idx, 32'(pq_inv[2].d), 32'hFF);
      chk("b2b.gap",  pq_inv[2].idx, 32'(pq_inv[2].idx - pq_inv[1].idx), 32'd40);
      chk("3c.kind",  pq_inv[3].idx, 32'(pq_inv[3].is_err), 32'd1);
      chk("3c.idx",   pq_inv[3].idx, 32'(pq_inv[3].idx - s_3c), 32'd40);
      chk("3c.held",  pq_inv[3].idx, 32'(pq_inv[3].d), 32'hFF);
    end
    bcnt = 0;
    for (int i = g_idx; i < g_idx + 9; i++) bcnt += int'(bh_inv[i]);
    chk("glitch.busy_1to3", g_idx, 32'(bcnt >= 1 && bcnt <= 3), 32'd1);

    // Segment 2: frame 0x5A cut off mid data bits by reset.
    lv.delete();
    add_idle(4);
    add_frame(8'h5A, 1'b1, s_5a);
    while (lv.size() > s_5a + CPB * 5) void'(lv.pop_back());
    build_model(last_d);
    run_seg();
    chk("abort.npulses", s_5a, 32'(pq_inv.size()), 32'd0);
    chk("abort.busy", s_5a, 32'(bz_i), 32'd1);
    lg    = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_zero(-2);
    repeat (3) begin
      @(negedge clk);
      chk_zero(-2);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Segment 3: recovery frame and true-polarity latency.
    lv.delete();
    add_idle(4);
    add_frame(8'h81, 1'b1, s_81);
    add_idle(6);
    add_frame(8'h12, 1'b1, s_12);
    add_idle(6);
    build_model(8'h00);
    run_seg();
    chk("seg3.inv_npulses", 0, 32'(pq_inv.size()), 32'd2);
    chk("seg3.true_npulses", 0, 32'(pq_true.size()), 32'd2);
    if (pq_inv.size() >= 1) begin
      chk("81.data", pq_inv[0].idx, 32'(pq_inv[0].d), 32'h81);
      chk("81.idx",  pq_inv[0].idx, 32'(pq_inv[0].idx - s_81), 32'd40);
    end
    if (pq_true.size() >= 2) begin
      chk("12.data", pq_true[1].idx, 32'(pq_true[1].d), 32'h12);
      // Drive edge to data_valid edge is 41 cycles; index difference counts edges after the drive.
      chk("12.latency", pq_true[1].idx, 32'(pq_true[1].idx - s_12 + 1), 32'd41);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inv_serial_rx.md
# inv_serial_rx

Serial frame receiver for a single-wire link whose transmitter drives the line through an inverter stage. It synchronizes the incoming line and undoes the polarity inversion. It detects start bits, samples each data bit at mid-bit, checks the stop bit, and presents each received word as a one-cycle valid pulse. It sits at the receiving end of the link and is the counterpart of the line driver/inverter chain on the sending side.

## Interface
- CLKS_PER_BIT, 16, clock cycles per serial bit; must be ≥ 4 and even.
- DATA_BITS, 8, data bits per frame, LSB first; range 5..9.
- INVERT, 1, 1 = physical line is inverted (idle low); 0 = line is true polarity (idle high).
- clk  input  1  sole clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- line_in  input  1  raw serial line, asynchronous to clk.
- data_out  output  DATA_BITS  last correctly framed word; held until the next good frame.
- data_valid  output  1  one-cycle pulse: data_out just updated.
- frame_err  output  1  one-cycle pulse: stop bit sampled at the wrong level; data_out not updated.
- busy  output  1  high whenever the FSM is not in IDLE.

## Operation
- Logical line: `l = sync(line_in) ^ INVERT`. The 2-flop synchronizer resets to the idle level, so `l = 1` out of reset.
- Logical idle = 1, start bit = 0, data bits LSB first, stop bit = 1.
- FSM states and transitions:
  - IDLE: on `l == 0`, clear the bit counter, load the cycle counter with CLKS_PER_BIT/2 − 1, go to START.
  - START: at cycle-counter zero (mid start bit), resample `l`.
    - `l == 0`: go to DATA and reload the counter with CLKS_PER_BIT − 1.
    - `l == 1`: glitch. Return to IDLE with no pulse.
  - DATA: at each counter zero, shift `l` into the MSB of the shift register (right shift) and reload the counter. After DATA_BITS samples, go to STOP.
  - STOP: at counter zero, sample `l`.
    - `l == 1`: load data_out from the shift register and pulse data_valid.
    - `l == 0`: pulse frame_err.
    - Either way, go to IDLE.
- Back-to-back frames: IDLE can detect a new start bit in the cycle immediately after leaving STOP.
- Width rules:
  - Cycle counter is `$clog2(CLKS_PER_BIT)` bits.
  - Bit counter is `$clog2(DATA_BITS+1)` bits.
  - Neither counter may wrap; both are reloaded explicitly.
- Reset values (also apply on reset mid-frame):
  - data_out = 0, data_valid = 0, frame_err = 0, busy = 0.
  - FSM = IDLE, counters = 0, shift register = 0, synchronizer = idle level.
- A partial frame interrupted by reset produces no pulse.

## Timing
- line_in reaches `l` after 2 clk edges.
- The start edge is seen in IDLE on the cycle `l` first reads 0. busy rises on the next edge.
- Mid-bit sample points fall CLKS_PER_BIT/2 + k·CLKS_PER_BIT cycles after start detection, for k = 0 (start) through DATA_BITS + 1 (stop).
- data_valid / frame_err are registered. They assert in the cycle after the stop-bit sample and last exactly 1 cycle; busy falls in that same cycle.
- Total latency from the line_in start edge to data_valid: 2 + CLKS_PER_BIT/2 + (DATA_BITS+1)·CLKS_PER_BIT + 1 cycles.
- data_valid and frame_err are mutually exclusive.

## Structure
- Package `inv_serial_pkg` holds:
  - the state enum `rx_state_t` (IDLE, START, DATA, STOP);
  - localparams for the logical idle, start and stop levels.
- Sub-module `line_sync`: a 2-flop synchronizer with a parameterized reset value, instantiated once for line_in. It is reused elsewhere in the design.
- Top level contains the FSM, both counters, the shift register and the output registers.

## Test plan
All scenarios use CLKS_PER_BIT = 4 and DATA_BITS = 8.
- INVERT = 1. Send 0xA5 (physical: start high, data inverted, stop low) -> one data_valid pulse, data_out = 0xA5, frame_err never high, busy low afterwards.
- INVERT = 1. Send 0x00 then 0xFF back-to-back with no idle gap -> two data_valid pulses exactly 40 cycles apart; data_out = 0x00, then 0xFF.
- Logical start glitch 1 cycle wide -> no pulse; busy high for ≤ 3 cycles; FSM back in IDLE; data_out unchanged.
- Frame 0x3C with stop bit forced logical 0 -> frame_err pulses once, data_valid stays 0, data_out keeps the previous value (0xFF).
- Assert rst_n low mid-way through the data bits of 0x5A, release, then send 0x81 -> no pulse for the aborted frame; all outputs 0 during reset; 0x81 received correctly.
- INVERT = 0. Send 0x12 on a true-polarity line -> data_out = 0x12. Latency from start edge to data_valid = 2 + 2 + 36 + 1 = 41 cycles.
